mem_responder: RTL
==================

# mem_responder

Target-side responder for the team's single-port valid/ready memory bus. Holds a WIDTH x DEPTH register-file memory, drives `ready` and `rdata` in answer to an initiator's `valid`/`write`/`addr`/`wdata`, and inserts a fixed number of wait states. The bus checker's rules bind this block: `ready` arrives 1-4 cycles after `valid`, and `rdata` is 0 in reset. The block also flags initiator-side protocol violations.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 32, number of memory words
- ADDR_WIDTH, $clog2(DEPTH), address width
- WAIT_CYCLES, 1, wait states inserted before `ready` (legal 0..3)

- clk  input  1  rising-edge clock; only clock in the block
- rst  input  1  synchronous, active-high reset
- valid  input  1  initiator request; held high until the handshake completes
- write  input  1  1 = write, 0 = read; qualified by `valid`
- addr  input  ADDR_WIDTH  word address; qualified by `valid`
- wdata  input  WIDTH  write data; qualified by `valid && write`
- ready  output  1  registered completion strobe; transfer completes on `valid && ready`
- rdata  output  WIDTH  registered read data; holds the last read value
- busy  output  1  high while a request is latched and not yet completed
- proto_err  output  1  one-cycle pulse on an initiator protocol violation

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:**
  - `valid=1` latches `write`, `addr`, `wdata` into request registers and loads `cnt = WAIT_CYCLES`.
  - Next state is RESP if WAIT_CYCLES==0, otherwise WAIT.
- **WAIT:** `cnt` decrements each cycle. When `cnt==1`, next state is RESP.
- **RESP:**
  - `ready=1` for exactly this cycle.
  - If `valid=1`, the transfer completes.
    - Write: `mem[addr_q] <= wdata_q`.
    - Read: `rdata <= mem[addr_q]`, visible the cycle after RESP.
  - Next state is always IDLE. `ready` is never high for two consecutive cycles.
- **Abort:** `valid` drops in WAIT or RESP.
  - `proto_err` pulses.
  - The request is discarded: no memory write and no `rdata` update.
  - FSM returns to IDLE.
- **Stability:** `addr`, `write` or `wdata` differs from the latched value while in WAIT with `valid=1`.
  - `proto_err` pulses.
  - The transfer proceeds using the latched values.
- Write data is never forwarded to `rdata`. `rdata` changes only on read completion.
- An out-of-range `addr` (DEPTH not a power of 2) reads 0 and ignores writes.
- `busy = (state != IDLE)`.

## Timing
- **Reset values:** `ready=0`, `rdata=0`, `busy=0`, `proto_err=0`, state=IDLE, `cnt=0`, all memory words 0.
- **Reset mid-operation:** `rst` wins over everything. A pending write is not committed and `rdata` is forced to 0 that same edge.
- **Latency:** if `valid` is first sampled in IDLE at edge T, `ready` is high in cycle T+1+WAIT_CYCLES. This is 1..4 cycles, meeting the bus rule.
- **Read data:** valid from cycle T+2+WAIT_CYCLES onward.
- **Back-to-back:** `valid` held high after a completion is sampled in IDLE the cycle after RESP. Minimum throughput is one transfer per WAIT_CYCLES+2 cycles.
- **Counter:** width is 2 bits. WAIT_CYCLES > 3 is illegal, and an elaboration-time error is required.
- **`proto_err` timing:** registered, asserted the cycle after the offending sample.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `valid=1` -> `ready=0`, `rdata=0x00`, `busy=0` throughout. Afterwards, a read of addr 5 returns 0x00.
- **Write/read, WAIT_CYCLES=2:**
  - Write 0xA5 to addr 7 at T -> `ready` high only at T+3.
  - Read addr 7 -> `ready` at T'+3, and `rdata=0xA5` from T'+4.
- **Back-to-back with wrap:**
  - Stimulus: `valid` held high while writing 0x11 to addr 31 and then 0x22 to addr 0, then reading both.
  - Response: `ready` pulses spaced WAIT_CYCLES+2 apart, reads return 0x11 and 0x22, and addr 0 is not aliased onto addr 31.
- **Abort:** write 0x3C to addr 12, drop `valid` in WAIT -> `proto_err` pulses once, FSM returns to IDLE, and a subsequent read of addr 12 returns the old value 0x00.
- **Stability violation:** change `wdata` from 0x0F to 0xF0 during WAIT of a write to addr 3 -> `proto_err` pulses and addr 3 holds 0x0F.
- **Reset mid-read, WAIT_CYCLES=3:** assert `rst` in WAIT -> `ready` never pulses, `rdata=0x00`, and a new request after reset completes at normal latency (T+4).

Source files
------------

// File: rtl/mem_responder.sv
// Valid/ready memory-bus target: register-file memory with a fixed number of
// wait states ahead of a one-cycle ready strobe, plus initiator protocol checks.
module mem_responder #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 32,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  proto_err
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 3) begin : g_bad_wait
            $error("mem_responder: WAIT_CYCLES must be in 0..3");
        end
    endgenerate

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic load, do_wr, do_rd, err_d, mismatch, in_range;

    assign mismatch = (addr != addr_q) || (write != write_q) || (wdata != wdata_q);
    // Extra bit keeps the compare exact when DEPTH is a power of two.
    assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    load    = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!valid) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d = mismatch;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (valid) begin
                    do_wr = write_q;
                    do_rd = !write_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready     <= 1'b0;
            rdata     <= '0;
            proto_err <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready     <= (state_d == RESP);
            proto_err <= err_d;
            if (load) begin
                write_q <= write;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (do_wr && in_range) mem[addr_q] <= wdata_q;
            if (do_rd) rdata <= in_range ? mem[addr_q] : '0;
        end
    end

endmodule
